// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream, instruction-memory write port and boot status bundle
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic                  wr_enable;
  logic                  cpu_hold;
  logic                  done;
  logic                  error;

  modport master (
    output in_data, in_valid,
    input  in_ready, wr_addr, wr_data, wr_enable, cpu_hold, done, error
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, wr_addr, wr_data, wr_enable, cpu_hold, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader writing big-endian words to instruction memory, XOR-checked
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus
);
  localparam logic [2:0] S_CNT_HI = 3'd0;
  localparam logic [2:0] S_CNT_LO = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_CSUM   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;
  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  logic [2:0]            r_state;
  logic [15:0]           r_count;
  logic [1:0]            r_byte_idx;
  logic [ADDR_WIDTH-1:0] r_word_idx;
  logic [7:0]            r_xor;
  logic [31:0]           r_word;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [31:0]           r_wr_data;
  logic                  r_wr_enable;
  logic                  r_cpu_hold;
  logic                  r_done;
  logic                  r_error;

  logic                  w_ready;
  logic                  w_accept;
  logic [15:0]           w_count_full;
  logic [31:0]           w_word_asm;
  logic [7:0]            w_xor_next;
  logic                  w_last_word;

  assign w_ready      = (r_state == S_CNT_HI) || (r_state == S_CNT_LO) ||
                        (r_state == S_DATA)   || (r_state == S_CSUM);
  assign w_accept     = bus.in_valid && w_ready;
  assign w_count_full = {r_count[15:8], bus.in_data};
  assign w_word_asm   = {r_word[23:0], bus.in_data};
  assign w_xor_next   = r_xor ^ bus.in_data;
  // Word index is compared in 16 bits so N = DEPTH needs no extra index bit.
  assign w_last_word  = ({{(16-ADDR_WIDTH){1'b0}}, r_word_idx} == (r_count - 16'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_CNT_HI;
      r_count     <= '0;
      r_byte_idx  <= '0;
      r_word_idx  <= '0;
      r_xor       <= '0;
      r_word      <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_wr_enable <= 1'b0;
      r_cpu_hold  <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_wr_enable <= 1'b0;
      if (w_accept) begin
        r_xor <= w_xor_next;
        case (r_state)
          S_CNT_HI: begin
            r_count[15:8] <= bus.in_data;
            r_state       <= S_CNT_LO;
          end
          S_CNT_LO: begin
            r_count <= w_count_full;
            if ((w_count_full == 16'd0) || (w_count_full > DEPTH_W)) begin
              r_state <= S_ERR;
              r_error <= 1'b1;
            end else begin
              r_state <= S_DATA;
            end
          end
          S_DATA: begin
            r_word     <= w_word_asm;
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              r_wr_enable <= 1'b1;
              r_wr_addr   <= r_word_idx;
              r_wr_data   <= w_word_asm;
              if (w_last_word) begin
                r_state <= S_CSUM;
              end else begin
                r_word_idx <= r_word_idx + 1'b1;
              end
            end
          end
          S_CSUM: begin
            if (w_xor_next == 8'h00) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else begin
              r_state <= S_ERR;
              r_error <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.wr_enable = r_wr_enable;
  assign bus.cpu_hold  = r_cpu_hold;
  assign bus.done      = r_done;
  assign bus.error     = r_error;
endmodule
